// File: rtl/hex_digit_scanner_pkg.sv
// hex_digit_scanner_pkg: shared constants and types for the hex digit scanner.
//   NIBBLE_W        - width of one hex digit
//   NUM_DIGITS_DEF  - default number of scanned digits
//   REFRESH_DIV_DEF - default clk cycles per digit for the board clock
//   ANODE_OFF       - all-anodes-dark pattern (sized for up to 8 digits; slice to use)
//   digit_idx_t     - digit index type for the default digit count
package hex_digit_scanner_pkg;
    localparam int NIBBLE_W        = 4;
    localparam int NUM_DIGITS_DEF  = 4;
    localparam int REFRESH_DIV_DEF = 100000;
    localparam int IDX_W_DEF       = $clog2(NUM_DIGITS_DEF);
    localparam logic [7:0] ANODE_OFF = 8'hFF;
    typedef logic [IDX_W_DEF-1:0] digit_idx_t;
endpackage

// File: rtl/hex_digit_scanner_if.sv
// hex_digit_scanner_if: control and display bus of the hex digit scanner.
//   enable, load, value, blank_mask - driven by the master (user logic)
//   x, an, digit_idx, frame_done    - driven by the slave (scanner)
interface hex_digit_scanner_if #(
    parameter int NUM_DIGITS = hex_digit_scanner_pkg::NUM_DIGITS_DEF
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    logic                    enable;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [3:0]              x;
    logic [NUM_DIGITS-1:0]   an;
    logic [IDX_W-1:0]        digit_idx;
    logic                    frame_done;
    modport master (output enable, load, value, blank_mask, input x, an, digit_idx, frame_done);
    modport slave  (input enable, load, value, blank_mask, output x, an, digit_idx, frame_done);
endinterface

// File: rtl/hex_digit_scanner_prescaler.sv
// scan_prescaler: divides clk down to a one-cycle tick every REFRESH_DIV cycles while run=1.
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   run   - 1 = count, 0 = counter held at 0
//   tick  - high on the last cycle of each REFRESH_DIV period
module scan_prescaler
    import hex_digit_scanner_pkg::*;
#(
    parameter int REFRESH_DIV = REFRESH_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);
    localparam int CW = $clog2(REFRESH_DIV);
    logic [CW-1:0] count_q, count_d;
    assign tick    = run && (count_q == CW'(REFRESH_DIV - 1));
    assign count_d = (!run || tick) ? '0 : count_q + 1'b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end
endmodule

// File: rtl/hex_digit_scanner.sv
// hex_digit_scanner: time-multiplexes a double-buffered hex value onto one seven-segment decoder.
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of hex_digit_scanner_if (enable/load/value/blank_mask in,
//           x/an/digit_idx/frame_done out)
// Optional: define LEADING_ZERO_BLANK_EN to also darken leading zero digits (digit 0 never).
module hex_digit_scanner
    import hex_digit_scanner_pkg::*;
#(
    parameter int NUM_DIGITS  = NUM_DIGITS_DEF,
    parameter int REFRESH_DIV = REFRESH_DIV_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hex_digit_scanner_if.slave    bus
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int DW    = NIBBLE_W * NUM_DIGITS;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = ANODE_OFF[NUM_DIGITS-1:0];

    logic                  tick, wrap;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DW-1:0]         display_q, display_d, shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    logic [NIBBLE_W-1:0]   x_q, x_d;
    logic [NUM_DIGITS-1:0] an_q, an_d, blank;
    logic                  frame_done_q;

    scan_prescaler #(.REFRESH_DIV(REFRESH_DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (bus.enable),
        .tick  (tick)
    );

    assign wrap = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz;
    logic                  above_zero;
    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        lz         = '0;
        above_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            above_zero = above_zero && (display_q[NIBBLE_W*k +: NIBBLE_W] == '0);
            lz[k]      = above_zero;
        end
    end
    assign blank = bus.blank_mask | lz;
`else
    assign blank = bus.blank_mask;
`endif

    always_comb begin
        idx_d     = !bus.enable ? '0 : wrap ? '0 : tick ? idx_q + 1'b1 : idx_q;
        display_d = display_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        // A load while idle or on the wrap edge goes straight to the display and
        // supersedes anything still waiting in the shadow register.
        if (bus.load && (!bus.enable || wrap)) begin
            display_d = bus.value;
            pending_d = 1'b0;
        end else if (wrap && pending_q) begin
            display_d = shadow_q;
            pending_d = 1'b0;
        end else if (bus.load) begin
            shadow_d  = bus.value;
            pending_d = 1'b1;
        end
        x_d  = display_q[NIBBLE_W*idx_q +: NIBBLE_W];
        an_d = (bus.enable && !blank[idx_q]) ? ~(NUM_DIGITS'(1) << idx_q) : AN_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            display_q    <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            x_q          <= '0;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            display_q    <= display_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            x_q          <= x_d;
            an_q         <= an_d;
            frame_done_q <= wrap;
        end
    end

    assign bus.x          = x_q;
    assign bus.an         = an_q;
    assign bus.digit_idx  = idx_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_hex_digit_scanner.sv
// tb_hex_digit_scanner: directed self-checking bench for hex_digit_scanner (4 digits, REFRESH_DIV=4).
module tb_hex_digit_scanner;
    import hex_digit_scanner_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    hex_digit_scanner_if #(.NUM_DIGITS(4)) bus ();

    hex_digit_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Display content of each frame after scanning starts at j=0:
    // frames 0,1 old value; BEEF loaded mid frame 1 lands in frame 2;
    // 9999 pending in frame 2 is superseded by 0042 loaded on the wrap.
    function automatic logic [15:0] frame_val(input int f);
        return (f < 2) ? 16'h1A3F : (f == 2) ? 16'hBEEF : 16'h0042;
    endfunction

    initial begin
        logic [15:0] v;
        logic [3:0]  mask, exp_an;
        digit_idx_t  d;
        bit          blk;
        bus.enable     = 1'b0;
        bus.load       = 1'b0;
        bus.value      = '0;
        bus.blank_mask = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset an", 32'(bus.an), 32'hF);
        check("reset x", 32'(bus.x), 32'h0);
        check("reset idx", 32'(bus.digit_idx), 32'h0);
        check("reset frame_done", 32'(bus.frame_done), 32'h0);
        // Idle load goes straight to the display.
        bus.load  = 1'b1;
        bus.value = 16'h1A3F;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (2) @(negedge clk);
        check("idle an dark", 32'(bus.an), 32'hF);
        bus.enable = 1'b1;
        for (int j = 0; j < 80; j++) begin
            @(negedge clk);
            v    = frame_val(j / 16);
            d    = digit_idx_t'((j / 4) % 4);
            mask = (j >= 64) ? 4'b0100 : 4'b0000;
            blk  = mask[d];
`ifdef LEADING_ZERO_BLANK_EN
            if (v == 16'h0042 && d >= 2) blk = 1'b1;
`endif
            exp_an = blk ? 4'hF : ~(4'b0001 << d);
            check($sformatf("an j=%0d", j), 32'(bus.an), 32'(exp_an));
            check($sformatf("x j=%0d", j), 32'(bus.x), 32'((v >> (4 * d)) & 16'hF));
            check($sformatf("idx j=%0d", j), 32'(bus.digit_idx), 32'(((j + 1) / 4) % 4));
            check($sformatf("frame_done j=%0d", j), 32'(bus.frame_done), 32'(j % 16 == 15));
            bus.load  = (j + 1 == 20) || (j + 1 == 36) || (j + 1 == 47);
            bus.value = (j + 1 == 20) ? 16'hBEEF : (j + 1 == 36) ? 16'h9999 : 16'h0042;
            bus.blank_mask = (j + 1 >= 64) ? 4'b0100 : 4'b0000;
        end
        bus.load       = 1'b0;
        bus.blank_mask = '0;
        bus.enable     = 1'b0;
        @(negedge clk);
        check("disabled an", 32'(bus.an), 32'hF);
        check("disabled idx", 32'(bus.digit_idx), 32'h0);
        check("disabled frame_done", 32'(bus.frame_done), 32'h0);
        bus.load  = 1'b1;
        bus.value = 16'h5678;
        @(negedge clk);
        bus.load = 1'b0;
        @(negedge clk);
        check("disabled an after load", 32'(bus.an), 32'hF);
        bus.enable = 1'b1;
        @(negedge clk);
        check("reenable an", 32'(bus.an), 32'hE);
        check("reenable x", 32'(bus.x), 32'h8);
        check("reenable idx", 32'(bus.digit_idx), 32'h0);
        repeat (2) @(negedge clk);
        bus.load  = 1'b1;
        bus.value = 16'hAAAA;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset an", 32'(bus.an), 32'hF);
        check("async reset x", 32'(bus.x), 32'h0);
        check("async reset idx", 32'(bus.digit_idx), 32'h0);
        check("async reset frame_done", 32'(bus.frame_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("pending discarded x", 32'(bus.x), 32'h0);
        check("post reset idx", 32'(bus.digit_idx), 32'h1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hex_digit_scanner.md
Name: hex_digit_scanner

Overview:
Time-multiplexes a multi-digit hex value onto one shared seven-segment decoder. It cycles a digit index at a refreshable rate and drives the active-low anode enable for the selected digit. It presents that digit's 4-bit nibble on x, which feeds the downstream hex-to-seven-segment decoder. New values are double-buffered and applied only at frame boundaries, so the display never shows a torn value.

Parameters:
NUM_DIGITS, 4, number of digits scanned; must be 2..8
REFRESH_DIV, 100000, clk cycles each digit is held; must be ≥2
IDX_W, $clog2(NUM_DIGITS), digit index width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = scanning, 0 = display off, scan held
load  in  1  single-cycle strobe: capture value
value  in  4*NUM_DIGITS  hex value; digit 0 = bits [3:0]
blank_mask  in  NUM_DIGITS  1 = force that digit dark
x  out  4  nibble for the current digit, to the decoder
an  out  NUM_DIGITS  active-low anode enables, one-hot-low or all-1
digit_idx  out  IDX_W  currently displayed digit
frame_done  out  1  one-cycle pulse when the index wraps NUM_DIGITS-1 -> 0

Behaviour:
- Reset (async assert, sync deassert in the using design):
  - prescaler = 0, digit_idx = 0
  - display and shadow registers = 0, pending = 0
  - an = all 1s, x = 0, frame_done = 0
- Prescaler counts 0..REFRESH_DIV-1 while enable=1. tick = (count == REFRESH_DIV-1); count wraps to 0 on tick.
- On tick: digit_idx <= (digit_idx == NUM_DIGITS-1) ? 0 : digit_idx+1.
- Frame wrap is a tick with digit_idx == NUM_DIGITS-1. On wrap:
  - frame_done pulses high the following cycle, for exactly 1 cycle.
  - If pending, display <= shadow and pending <= 0.
- Load with enable=1 and no wrap this cycle: shadow <= value, pending <= 1. A repeated load before the wrap overwrites shadow; last load wins.
- Load coincident with wrap: display <= value directly (the load wins over shadow), and pending <= 0.
- enable=0:
  - Prescaler and digit_idx are held at 0.
  - an = all 1s, frame_done = 0.
  - load writes display immediately and clears pending.
- Rising enable: scanning starts at digit 0, count 0. The first tick occurs REFRESH_DIV cycles later.
- Outputs x and an are registered from digit_idx and display, with 1 cycle latency after a digit_idx change.
  - x = display[4*idx +: 4].
  - an[idx] = 0, all other bits 1, unless blank_mask[idx] = 1, in which case an = all 1s for that slot.
  - x still carries the nibble when blanked.
- blank_mask is sampled every cycle and is not buffered.
- Reset asserted mid-frame returns all state to reset values immediately. Pending data is discarded.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: a digit k ≥ 1 is blanked (an stays all 1s in its slot) when display digits NUM_DIGITS-1 down to k are all zero. Digit 0 is never auto-blanked. This is ORed with blank_mask.
- Undefined: only blank_mask blanks digits; there is no extra logic.

Decomposition:
- Shared package holds:
  - ANODE_OFF constant (all 1s) and the NIBBLE_W = 4 constant.
  - The digit_idx_t typedef sized from NUM_DIGITS.
  - Default REFRESH_DIV for the board clock.
- One sub-module, scan_prescaler: parameter REFRESH_DIV; ports clk, rst_n, run, tick.
- Buffering, index and output logic stay in hex_digit_scanner.

Test Plan:
All scenarios use REFRESH_DIV=4, NUM_DIGITS=4.
- Reset mid-scan: assert rst_n=0 at an arbitrary cycle -> an=4'b1111, x=0, digit_idx=0 that same cycle, before the next clk edge.
- Scan order: enable=1, display=16'h1A3F -> an sequences 1110, 1101, 1011, 0111, each held 4 cycles; x sequences F, 3, A, 1; frame_done pulses once per 16 cycles.
- Tear-free load: load value=16'hBEEF mid-frame -> x shows the old digits until the wrap, then F, E, E, B in the next frame.
- Load on wrap cycle: load 16'h0042 on exactly the wrap cycle, with an older pending 16'h9999 -> the next frame shows 2, 4, 0, 0; 9999 is never displayed.
- Blanking and enable: blank_mask=4'b0100 -> an never equals 1011. With LEADING_ZERO_BLANK_EN and display=16'h0042, the an slots for digits 3 and 2 stay 1111. enable=0 -> an=1111 and a load is visible immediately on re-enable at digit 0.
